// File: rtl/psram_arb_pkg.sv
// rtl/psram_arb_pkg.sv - shared types and constants for the PSRAM arbiter
//
// Holds the arbiter FSM state encoding, the operator command codes and the
// default values of the arbiter parameters.
package psram_arb_pkg;

  localparam int ADDR_W_DEF  = 23;
  localparam int LEN_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 4096;

  localparam logic [1:0] CMD_SWR = 2'b00;
  localparam logic [1:0] CMD_BWR = 2'b01;
  localparam logic [1:0] CMD_SRD = 2'b10;
  localparam logic [1:0] CMD_BRD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arbState_t;

endpackage

// File: rtl/psram_arb_pick.sv
// rtl/psram_arb_pick.sv - winner selection between capture-writer and upload-reader
//
// Purely combinational. The writer wins whenever its urgent flag is set,
// otherwise a tie goes to whoever was not served last.
//
// Ports:
//   reqW, reqR  requests from writer / reader
//   urgentW     writer FIFO almost-full, overrides round-robin
//   lastR       1 when the reader was the last requester served
//   anyReq      at least one request pending
//   pickR       1 when the reader wins, 0 when the writer wins
module psram_arb_pick
  import psram_arb_pkg::*;
(
  input  logic reqW,
  input  logic reqR,
  input  logic urgentW,
  input  logic lastR,
  output logic anyReq,
  output logic pickR
);

  assign anyReq = reqW | reqR;

  always_comb begin
    pickR = 1'b1;
    // Writer wins if urgent, if alone, or if the reader had the last turn.
    if (reqW && (urgentW || !reqR || lastR)) begin
      pickR = 1'b0;
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// rtl/psram_arbiter.sv - two-port arbiter in front of the PSRAM operator
//
// Grants the shared PSRAM operator to either the capture-writer (W) or the
// upload-reader (R), latches the winner's command, runs it through
// IDLE -> ISSUE -> WAIT -> DONE and aborts via a watchdog if the operator
// never reports completion.
//
// Ports:
//   iClk, iRst              clock, asynchronous active-high reset
//   iEn                     allow new grants
//   iReqW/R, iCmdW/R,
//   iAddrW/R, iLenW/R       requester command interfaces
//   iUrgentW                writer FIFO almost-full
//   oGntW/R                 grant, high from grant cycle through DONE
//   oDoneW/R                one-cycle completion pulse
//   oRamEn, oRamCmd,
//   oRamAddr, oRamLen       latched command to the operator
//   iRamBusy, iRamDone      operator handshake
//   oTimeout                one-cycle watchdog abort pulse
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  input  logic              iReqW,
  input  logic              iReqR,
  input  logic [1:0]        iCmdW,
  input  logic [1:0]        iCmdR,
  input  logic [ADDR_W-1:0] iAddrW,
  input  logic [ADDR_W-1:0] iAddrR,
  input  logic [LEN_W-1:0]  iLenW,
  input  logic [LEN_W-1:0]  iLenR,
  input  logic              iUrgentW,
  output logic              oGntW,
  output logic              oGntR,
  output logic              oDoneW,
  output logic              oDoneR,
  output logic              oRamEn,
  output logic [1:0]        oRamCmd,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic [LEN_W-1:0]  oRamLen,
  input  logic              iRamBusy,
  input  logic              iRamDone,
  output logic              oTimeout
);

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  arbState_t   state;
  arbState_t   stateNext;
  logic        ownerR;     // 1 while the reader owns the operator
  logic        lastR;      // 1 when the reader was served last
  logic [15:0] wdog;
  logic        wdogHit;
  logic        anyReq;
  logic        pickR;
  logic        doGrant;
  logic        doTimeout;

  psram_arb_pick uPick (
    .reqW    (iReqW),
    .reqR    (iReqR),
    .urgentW (iUrgentW),
    .lastR   (lastR),
    .anyReq  (anyReq),
    .pickR   (pickR)
  );

  assign wdogHit = (wdog == WDOG_LAST);

  always_comb begin
    stateNext = state;
    doGrant   = 1'b0;
    doTimeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iEn && anyReq) begin
          doGrant   = 1'b1;
          stateNext = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Completion beats the watchdog, and the watchdog beats busy.
        if (iRamDone) begin
          stateNext = ST_DONE;
        end else if (wdogHit) begin
          doTimeout = 1'b1;
          stateNext = ST_IDLE;
        end else if (iRamBusy) begin
          stateNext = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (iRamDone) begin
          stateNext = ST_DONE;
        end else if (wdogHit) begin
          doTimeout = 1'b1;
          stateNext = ST_IDLE;
        end
      end
      ST_DONE: begin
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= ST_IDLE;
      ownerR   <= 1'b0;
      lastR    <= 1'b1;
      wdog     <= 16'd0;
      oRamCmd  <= 2'b00;
      oRamAddr <= '0;
      oRamLen  <= '0;
      oTimeout <= 1'b0;
    end else begin
      state    <= stateNext;
      oTimeout <= doTimeout;
      if (doGrant) begin
        ownerR   <= pickR;
        oRamCmd  <= pickR ? iCmdR  : iCmdW;
        oRamAddr <= pickR ? iAddrR : iAddrW;
        oRamLen  <= pickR ? iLenR  : iLenW;
        wdog     <= 16'd0;
      end else if (state == ST_ISSUE || state == ST_WAIT) begin
        wdog <= wdog + 16'd1;
      end
      // An aborted transaction still counts as a turn for round-robin.
      if (state == ST_DONE || doTimeout) begin
        lastR <= ownerR;
      end
    end
  end

  // Grant covers ISSUE, WAIT and DONE; IDLE is the only ungranted state.
  assign oGntW  = (state != ST_IDLE) && !ownerR;
  assign oGntR  = (state != ST_IDLE) &&  ownerR;
  assign oDoneW = (state == ST_DONE) && !ownerR;
  assign oDoneR = (state == ST_DONE) &&  ownerR;
  assign oRamEn = (state == ST_ISSUE);

endmodule
